bram_lsu: RTL and testbench

- Load/store initiator that drives the single-port, read-first, byte-write-enable BRAM used as data memory in the rvj1 testbench and SoC.
- Accepts one load/store request at a time from the core over a valid/ready handshake.
- Converts each request into byte-lane write enables with replicated write data, or into a read followed by lane extraction and sign/zero extension.
- Returns one response per request over a valid/ready handshake.

---
 rtl/bram_lsu.sv | 166 ++++++++++++++++
 tb/tb_bram_lsu.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/bram_lsu.sv
// Load/store initiator for a single-port, read-first, byte-enabled data BRAM.
// One request in flight; stores become lane enables, loads are extracted and extended.
module bram_lsu #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_di,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic [1:0]            dbg_state
);

  // Both ports are valid/ready: a transfer happens on a rising edge where valid and
  // ready are both high; the producer holds valid and its payload until that edge.
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, CAPTURE = 2'd2, RESP = 2'd3} state_e;

  state_e                state_q, state_d;
  logic [3:0]            mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_di_q, mem_di_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [1:0]            lane_q, lane_d;

  logic                  illegal;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;

  assign illegal = (req_size == 2'b11) ||
                   ((req_size == 2'b01) && req_addr[0]) ||
                   ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

  always_comb begin
    byte_sel = 8'h00;
    case (lane_q)
      2'd0:    byte_sel = mem_dout[7:0];
      2'd1:    byte_sel = mem_dout[15:8];
      2'd2:    byte_sel = mem_dout[23:16];
      default: byte_sel = mem_dout[31:24];
    endcase
    half_sel = lane_q[1] ? mem_dout[31:16] : mem_dout[15:0];
  end

  always_comb begin
    state_d    = state_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_di_d   = mem_di_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    we_d       = we_q;
    size_d     = size_q;
    uns_d      = uns_q;
    lane_d     = lane_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          lane_d  = req_addr[1:0];
          rdata_d = '0;
          if (illegal) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            mem_addr_d = req_addr;
            state_d    = ACCESS;
            case (req_size)
              2'b00: begin
                mem_we_d = 4'b0001 << req_addr[1:0];
                mem_di_d = {4{req_wdata[7:0]}};
              end
              2'b01: begin
                mem_we_d = req_addr[1] ? 4'b1100 : 4'b0011;
                mem_di_d = {2{req_wdata[15:0]}};
              end
              default: begin
                mem_we_d = 4'b1111;
                mem_di_d = req_wdata;
              end
            endcase
            if (!req_we) mem_we_d = 4'b0000;
          end
        end
      end
      ACCESS: begin
        mem_we_d = 4'b0000;
        if (we_q) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = RESP;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        case (size_q)
          2'b00:   rdata_d = {{24{~uns_q & byte_sel[7]}}, byte_sel};
          2'b01:   rdata_d = {{16{~uns_q & half_sel[15]}}, half_sel};
          default: rdata_d = mem_dout;
        endcase
        state_d = RESP;
      end
      default: begin
        if (rsp_ready) begin
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      mem_we_q   <= 4'b0000;
      mem_addr_q <= '0;
      mem_di_q   <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      lane_q     <= 2'b00;
    end else begin
      state_q    <= state_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_di_q   <= mem_di_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      we_q       <= we_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      lane_q     <= lane_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_di    = mem_di_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bram_lsu.sv
// Directed bench for bram_lsu with a read-first byte-enabled BRAM model attached.
module tb_bram_lsu;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_di, mem_dout;
  logic [1:0]  dbg_state;

  logic [31:0] ram [0:63];
  int n_total = 0;
  int n_bad   = 0;

  bram_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_di(mem_di), .mem_dout(mem_dout),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_dout <= ram[mem_addr[7:2]];
    for (int i = 0; i < 4; i++)
      if (mem_we[i]) ram[mem_addr[7:2]][8*i +: 8] <= mem_di[8*i +: 8];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One request; with hold>0 the response is back-pressured and the request re-presented.
  task automatic txn(input string tag, input logic we, input logic [1:0] size,
                     input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                     input logic [3:0] exp_we0, input logic [31:0] exp_di0, input int hold);
    int lat;
    int budget;
    logic [3:0] we_or;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; rsp_ready = 1'b0;
    budget = 0;
    while (!req_ready && budget < 20) begin @(negedge clk); budget++; end
    if (!req_ready) check({tag, "_accept_timeout"}, 0, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    check({tag, "_we0"}, mem_we, exp_we0);
    if (exp_we0 != 4'b0000) check({tag, "_di0"}, mem_di, exp_di0);
    we_or = mem_we;
    while (!rsp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
      we_or |= mem_we;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_rdata"}, rsp_rdata, exp_rdata);
    check({tag, "_err"}, rsp_err, exp_err);
    if (exp_err) check({tag, "_we_never"}, we_or, 0);
    for (int i = 0; i < hold; i++) begin
      if (i == 1) req_valid = 1'b1;
      @(posedge clk); #1;
      check({tag, "_bp_valid"}, rsp_valid, 1);
      check({tag, "_bp_rdata"}, rsp_rdata, exp_rdata);
      check({tag, "_bp_err"}, rsp_err, exp_err);
      check({tag, "_bp_ready"}, req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, "_valid_drop"}, rsp_valid, 0);
    if (hold > 0) begin
      check({tag, "_not_same_cycle"}, dbg_state, 2'd0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      check({tag, "_accept_next"}, dbg_state, 2'd1);
      budget = 0;
      while (!rsp_valid && budget < 10) begin @(posedge clk); #1; budget++; end
      check({tag, "_second_rdata"}, rsp_rdata, exp_rdata);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 32'h0;
    rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_di", mem_di, 0);
    check("rst_state", dbg_state, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    //   tag        we    size   uns   addr   wdata         rdata         err lat we0      di0         hold
    txn("st_w10",   1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        0, 2, 4'b1111, 32'hDEADBEEF, 0);
    txn("ld_w10",   1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 3, 4'b0000, 32'h0,        0);
    txn("st_b12",   1'b1, 2'b00, 1'b0, 32'h12, 32'h000000A5, 32'h0,        0, 2, 4'b0100, 32'hA5A5A5A5, 0);
    txn("ld_w10b",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'hDEA5BEEF, 0, 3, 4'b0000, 32'h0,        0);
    txn("ld_bs12",  1'b0, 2'b00, 1'b0, 32'h12, 32'h0,        32'hFFFFFFA5, 0, 3, 4'b0000, 32'h0,        0);
    txn("ld_bu12",  1'b0, 2'b00, 1'b1, 32'h12, 32'h0,        32'h000000A5, 0, 3, 4'b0000, 32'h0,        0);
    txn("ld_bs13",  1'b0, 2'b00, 1'b0, 32'h13, 32'h0,        32'hFFFFFFDE, 0, 3, 4'b0000, 32'h0,        0);
    txn("ld_bs10",  1'b0, 2'b00, 1'b0, 32'h10, 32'h0,        32'hFFFFFFEF, 0, 3, 4'b0000, 32'h0,        0);
    txn("st_h22",   1'b1, 2'b01, 1'b0, 32'h22, 32'h00008001, 32'h0,        0, 2, 4'b1100, 32'h80018001, 0);
    txn("ld_hs22",  1'b0, 2'b01, 1'b0, 32'h22, 32'h0,        32'hFFFF8001, 0, 3, 4'b0000, 32'h0,        0);
    txn("ld_hu22",  1'b0, 2'b01, 1'b1, 32'h22, 32'h0,        32'h00008001, 0, 3, 4'b0000, 32'h0,        0);
    txn("ld_hs10",  1'b0, 2'b01, 1'b0, 32'h10, 32'h0,        32'hFFFFBEEF, 0, 3, 4'b0000, 32'h0,        0);
    txn("st_b20",   1'b1, 2'b00, 1'b0, 32'h20, 32'h0000007C, 32'h0,        0, 2, 4'b0001, 32'h7C7C7C7C, 0);
    txn("err_w13",  1'b1, 2'b10, 1'b0, 32'h13, 32'hFFFFFFFF, 32'h0,        1, 1, 4'b0000, 32'h0,        0);
    txn("err_h21",  1'b1, 2'b01, 1'b0, 32'h21, 32'hFFFFFFFF, 32'h0,        1, 1, 4'b0000, 32'h0,        0);
    txn("err_s20",  1'b1, 2'b11, 1'b0, 32'h20, 32'hFFFFFFFF, 32'h0,        1, 1, 4'b0000, 32'h0,        0);
    txn("err_lw11", 1'b0, 2'b10, 1'b0, 32'h11, 32'h0,        32'h0,        1, 1, 4'b0000, 32'h0,        0);
    txn("rb_w10",   1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'hDEA5BEEF, 0, 3, 4'b0000, 32'h0,        0);
    txn("rb_w20",   1'b0, 2'b10, 1'b0, 32'h20, 32'h0,        32'h8001007C, 0, 3, 4'b0000, 32'h0,        0);
    txn("bp_bu12",  1'b0, 2'b00, 1'b1, 32'h12, 32'h0,        32'h000000A5, 0, 3, 4'b0000, 32'h0,        5);
    txn("st_w30",   1'b1, 2'b10, 1'b0, 32'h30, 32'h11111111, 32'h0,        0, 2, 4'b1111, 32'h11111111, 0);

    // Store aborted by reset while its write enables are on the bus.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h30; req_wdata = 32'h22222222;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rst_mid_access_we", mem_we, 4'b1111);
    #2 rstn = 1'b0;
    #1;
    check("rst_mid_we", mem_we, 0);
    check("rst_mid_state", dbg_state, 0);
    check("rst_mid_rsp_valid", rsp_valid, 0);
    check("rst_mid_req_ready", req_ready, 1);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    txn("ld_w30",   1'b0, 2'b10, 1'b0, 32'h30, 32'h0,        32'h11111111, 0, 3, 4'b0000, 32'h0,        0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
